mram_serial_host: RTL

- Host-side serial initiator for the FPGA MRAM controller.
- Takes one parallel request (20-bit address, 16-bit write data, read/write, word select) and shifts address and data out MSB-first on two serial lines.
- Drives the 3-bit read/write select and waits a fixed latency. For reads, captures the controller's serial readback into a 16-bit word.
- Sits between a test/CPU master and the controller's addr_in/data_in/read_write_sel/ser_data_out pins.

---
 rtl/mram_serial_host.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mram_serial_host.sv
// Serial initiator for the MRAM controller: shifts address/data out MSB-first,
// holds the read/write select through a fixed latency, then captures serial readback.
module mram_serial_host #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int WR_LAT = 4,
  parameter int RD_LAT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  output logic              o_ready,
  input  logic              i_wr,
  input  logic [1:0]        i_word_sel,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ser_addr,
  output logic              o_ser_data,
  output logic [2:0]        o_rw_sel,
  input  logic              i_ser_rx,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_done
);

  // state   | meaning
  // IDLE    | ready, waiting for req
  // SHIFT   | ADDR_W cycles of address/data on the serial lines
  // WAIT    | fixed controller latency (WR_LAT or RD_LAT)
  // CAPTURE | DATA_W cycles sampling ser_rx MSB-first
  // DONE    | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_WAIT, S_CAPTURE, S_DONE} state_t;

  localparam int M_AD    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int M_LAT   = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
  localparam int CNT_MAX = (M_AD > M_LAT) ? M_AD : M_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_SHIFT = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] C_WR    = CNT_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0] C_RD    = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] C_CAP   = CNT_W'(DATA_W - 1);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_tc;
  logic                r_wr;
  logic [1:0]          r_word_sel;
  logic [ADDR_W-1:0]   r_addr_sh;
  logic [ADDR_W-1:0]   r_data_sh;
  logic [DATA_W-1:0]   r_cap;
  logic [DATA_W-1:0]   r_rdata;

  assign w_tc = (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_req) w_next = S_SHIFT;
      S_SHIFT:   if (w_tc) w_next = S_WAIT;
      S_WAIT:    if (w_tc) w_next = r_wr ? S_DONE : S_CAPTURE;
      S_CAPTURE: if (w_tc) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Write data is zero-extended so its last bit leaves together with address bit 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_wr       <= 1'b0;
      r_word_sel <= 2'b00;
      r_addr_sh  <= '0;
      r_data_sh  <= '0;
      r_cap      <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_cnt      <= C_SHIFT;
            r_wr       <= i_wr;
            r_word_sel <= i_word_sel;
            r_addr_sh  <= i_addr;
            r_data_sh  <= ADDR_W'(i_wdata);
          end
        end
        S_SHIFT: begin
          r_addr_sh <= {r_addr_sh[ADDR_W-2:0], 1'b0};
          r_data_sh <= {r_data_sh[ADDR_W-2:0], 1'b0};
          if (w_tc) r_cnt <= r_wr ? C_WR : C_RD;
          else      r_cnt <= r_cnt - 1'b1;
        end
        S_WAIT: begin
          if (w_tc) r_cnt <= C_CAP;
          else      r_cnt <= r_cnt - 1'b1;
        end
        S_CAPTURE: begin
          r_cap <= {r_cap[DATA_W-2:0], i_ser_rx};
          if (!w_tc) r_cnt <= r_cnt - 1'b1;
        end
        S_DONE: begin
          if (!r_wr) r_rdata <= r_cap;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    o_ready    = (r_state == S_IDLE);
    o_done     = (r_state == S_DONE);
    o_rw_sel   = (r_state == S_IDLE) ? 3'b000 : {r_word_sel, r_wr};
    o_ser_addr = (r_state == S_SHIFT) & r_addr_sh[ADDR_W-1];
    o_ser_data = (r_state == S_SHIFT) & r_data_sh[ADDR_W-1];
    // The captured word is visible already in the DONE cycle, before r_rdata loads.
    o_rdata    = (r_state == S_DONE && !r_wr) ? r_cap : r_rdata;
  end

endmodule
